// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester arbiter for the register file write port
//
// Purpose: shares the single write port of the register file between the
// execute writeback (requester 0) and the load writeback (requester 1).
// Each requester uses a valid/ready handshake. An accepted write appears on
// RegWrite/WriteReg/WriteData one cycle later. A saturating count of accepted
// writes is kept for each requester.
//
// Build option: RR_ARB_EN
//   defined   - round-robin tie-break. The requester that was not granted last wins.
//   undefined - fixed priority. Requester 0 always wins a tie.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   en                            arbitration enable (0 blocks all accepts)
//   req0_valid/ready/reg/data     requester 0 (execute writeback) handshake
//   req1_valid/ready/reg/data     requester 1 (load writeback) handshake
//   RegWrite, WriteReg, WriteData registered register-file write port
//   grant_id                      source of the current RegWrite pulse
//   wr_cnt0, wr_cnt1              saturating accepted-write counters
module regfile_wr_arbiter #(
  parameter int DW = 32,
  parameter int AW = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_reg,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_reg,
  input  logic [DW-1:0] req1_data,
  output logic          RegWrite,
  output logic [AW-1:0] WriteReg,
  output logic [DW-1:0] WriteData,
  output logic          grant_id,
  output logic [CW-1:0] wr_cnt0,
  output logic [CW-1:0] wr_cnt1
);

  // Requester that received the most recent transfer. It changes only when a
  // transfer happens, so idle cycles keep the fairness state.
  logic lastGrant;
  logic grant0;
  logic grant1;

  // Each grant already includes its matching valid. At most one grant is high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (en && !reset) begin
      if (req0_valid && req1_valid) begin
`ifdef RR_ARB_EN
        if (lastGrant) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
`else
        grant0 = 1'b1;
`endif
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

`ifndef RR_ARB_EN
  // In fixed-priority mode lastGrant is still tracked but does not steer arbitration.
  logic unusedLastGrant;
  assign unusedLastGrant = lastGrant;
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      grant_id  <= 1'b0;
      lastGrant <= 1'b1;
      wr_cnt0   <= '0;
      wr_cnt1   <= '0;
    end else if (grant0) begin
      RegWrite  <= 1'b1;
      WriteReg  <= req0_reg;
      WriteData <= req0_data;
      grant_id  <= 1'b0;
      lastGrant <= 1'b0;
      if (wr_cnt0 != {CW{1'b1}}) begin
        wr_cnt0 <= wr_cnt0 + 1'b1;
      end
    end else if (grant1) begin
      RegWrite  <= 1'b1;
      WriteReg  <= req1_reg;
      WriteData <= req1_data;
      grant_id  <= 1'b1;
      lastGrant <= 1'b1;
      if (wr_cnt1 != {CW{1'b1}}) begin
        wr_cnt1 <= wr_cnt1 + 1'b1;
      end
    end else begin
      RegWrite <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 4x32 register file between two requesters: the execute writeback and the load writeback.
- Uses a valid/ready handshake on each requester side.
- Drives the register file's RegWrite, WriteReg and WriteData from a registered output stage.
- Keeps a saturating accepted-write count per requester for debug.

Parameters:
DW, 32, data width of a write.
AW, 2, register address width (2^AW registers).
CW, 8, width of each per-requester write counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  arbitration enable; when 0, no request is accepted.
req0_valid  input  1  requester 0 has a write pending.
req0_ready  output  1  requester 0 write is accepted this cycle.
req0_reg  input  AW  requester 0 destination register.
req0_data  input  DW  requester 0 write data.
req1_valid  input  1  requester 1 has a write pending.
req1_ready  output  1  requester 1 write is accepted this cycle.
req1_reg  input  AW  requester 1 destination register.
req1_data  input  DW  requester 1 write data.
RegWrite  output  1  register file write enable (registered).
WriteReg  output  AW  register file write address (registered).
WriteData  output  DW  register file write data (registered).
grant_id  output  1  source of the current RegWrite pulse (registered).
wr_cnt0  output  CW  writes accepted from requester 0 (saturating).
wr_cnt1  output  CW  writes accepted from requester 1 (saturating).

Behaviour:
- Reset (synchronous, high at a rising edge) sets the following:
  - RegWrite=0, WriteReg=0, WriteData=0, grant_id=0.
  - wr_cnt0=0, wr_cnt1=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset overrides any same-cycle accept. A request presented during reset is not accepted and is not counted.
- Ready generation is combinational from en, both valids and last_grant:
  - en=0 or reset=1: both readys are 0.
  - Only reqN_valid=1: reqN_ready=1.
  - Both valid: the requester not equal to last_grant gets ready=1 and the other gets 0.
  - At most one ready is high in any cycle.
  - A ready is never high while the matching valid is low.
- Transfer happens when reqN_valid && reqN_ready at a rising edge. On that same edge:
  - RegWrite<=1, WriteReg<=reqN_reg, WriteData<=reqN_data, grant_id<=N, last_grant<=N.
  - wr_cntN increments by 1 and saturates at 2^CW-1. No wrap.
- With no transfer at an edge:
  - RegWrite<=0.
  - WriteReg, WriteData, grant_id and last_grant hold their values.
- Latency: one cycle from accept to RegWrite high. The register file commits on the following edge. RegWrite is a one-cycle pulse per accepted write.
- Back-to-back accepts on consecutive cycles keep RegWrite high, with a new address and data each cycle. Throughput is one write per cycle.
- Requesters must hold valid, reg and data stable until ready. The arbiter does not buffer unaccepted requests.
- Both requesters targeting the same register: the writes are serialized in grant order. The later-granted write wins in the register file. No merging or dropping.
- Deasserting en mid-stream: requests are no longer accepted from that cycle. A write already in the output stage still pulses RegWrite.
- last_grant updates only on a transfer, so an idle cycle does not reset fairness.

Optional Feature:
Macro RR_ARB_EN.
- Defined: round-robin tie-break as described in Behaviour.
- Undefined: fixed priority. When both are valid, requester 0 always wins and requester 1 is accepted only when req0_valid=0. last_grant is still maintained but unused for arbitration. All other behaviour is identical.

Test Plan:
- Reset, then req0 alone with reg=2'b00, data=32'hABABABAB for one cycle -> req0_ready=1 in that cycle. Next cycle: RegWrite=1, WriteReg=0, WriteData=ABABABAB, grant_id=0, wr_cnt0=1. Cycle after: RegWrite=0.
- Both requesters held valid for 4 cycles (req0: reg 01, data BCBCBCBC; req1: reg 10, data CDCDCDCD) with RR_ARB_EN -> grants alternate 0,1,0,1; wr_cnt0=2, wr_cnt1=2; RegWrite high for 4 consecutive cycles. Without the macro -> all 4 grants go to req0 and req1_ready stays 0.
- Both requesters write reg 2'b11 simultaneously (req0 DEDEDEDE, req1 12345678) after reset -> req0 is granted first and req1 on the next cycle. A later read of reg 3 returns 12345678.
- en=0 with both valid for 3 cycles -> both readys stay 0, RegWrite stays 0, counters unchanged. Raising en gives a grant in the same cycle.
- Assert reset on the cycle a req1 transfer would occur -> no RegWrite pulse next cycle and wr_cnt1 stays 0.
- CW=2, req0 valid for 5 cycles -> wr_cnt0 reads 1,2,3,3,3 (saturates). RegWrite pulses all 5 cycles.
